// File: rtl/intc_if.sv
// Bus and interrupt signals between the CPU side and the interrupt controller.
// The controller takes the slave view; the CPU side (or a bench) takes the master view.
interface intc_if;
  logic [7:0]  irq;
  logic        sel;
  logic [1:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        hwint;

  modport master (
    output irq, sel, addr, rd, wr, data_in,
    input  data_out, hwint
  );

  modport slave (
    input  irq, sel, addr, rd, wr, data_in,
    output data_out, hwint
  );
endinterface

// File: rtl/intc.sv
// Eight-source priority interrupt controller: edge-latched pending bits, enable mask,
// claim/EOI in-service tracking and a registered preemption-aware hwint request.
module intc (
  input  logic  clk,
  input  logic  rst,
  intc_if.slave bus
);

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_ENABLE  = 2'd1,
    REG_CLAIM   = 2'd2,
    REG_EOI     = 2'd3
  } regSel_e;

  logic [7:0] pending_q, pending_d;
  logic [7:0] enable_q, enable_d;
  logic [7:0] inService_q, inService_d;
  logic [7:0] irqPrev_q;
  logic       hwint_q, hwint_d;

  regSel_e    regSel;
  logic       readEn;
  logic       writeEn;
  logic [7:0] rise;
  logic [7:0] eligible;
  logic       anyEligible;
  logic [2:0] bestId;
  logic [3:0] topIsr;
  logic       claim;
  logic       unusedDataIn;

  assign regSel       = regSel_e'(bus.addr);
  assign readEn       = bus.sel & bus.rd;
  // A simultaneous read wins, so the write strobe is masked by rd.
  assign writeEn      = bus.sel & bus.wr & ~bus.rd;
  assign rise         = bus.irq & ~irqPrev_q;
  assign eligible     = pending_q & enable_q;
  assign anyEligible  = |eligible;
  assign claim        = readEn && (regSel == REG_CLAIM) && anyEligible;
  assign unusedDataIn = ^bus.data_in[31:8];

  always_comb begin
    bestId = 3'd0;
    topIsr = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) bestId = 3'(i);
      if (inService_q[i]) topIsr = 4'(i);
    end
  end

  // Edge sets are applied last so they beat W1C and claim clears on the same bit.
  always_comb begin
    pending_d   = pending_q;
    enable_d    = enable_q;
    inService_d = inService_q;
    if (writeEn && (regSel == REG_PENDING)) pending_d = pending_d & ~bus.data_in[7:0];
    if (writeEn && (regSel == REG_ENABLE))  enable_d  = bus.data_in[7:0];
    if (writeEn && (regSel == REG_EOI))     inService_d[bus.data_in[2:0]] = 1'b0;
    if (claim) begin
      pending_d[bestId]   = 1'b0;
      inService_d[bestId] = 1'b1;
    end
    pending_d = pending_d | rise;
    hwint_d   = anyEligible && ({1'b0, bestId} < topIsr);
  end

  always_comb begin
    bus.data_out = 32'd0;
    if (readEn) begin
      unique case (regSel)
        REG_PENDING: bus.data_out = {24'd0, pending_q};
        REG_ENABLE:  bus.data_out = {24'd0, enable_q};
        REG_CLAIM:   bus.data_out = anyEligible ? {1'b1, 28'd0, bestId} : 32'd0;
        REG_EOI:     bus.data_out = {24'd0, inService_q};
      endcase
    end
  end

  // irqPrev resets high so sources already asserted at reset release do not latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= 8'h00;
      enable_q    <= 8'h00;
      inService_q <= 8'h00;
      irqPrev_q   <= 8'hFF;
      hwint_q     <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      inService_q <= inService_d;
      irqPrev_q   <= bus.irq;
      hwint_q     <= hwint_d;
    end
  end

  assign bus.hwint = hwint_q;

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: a table of one-cycle bus vectors followed by
// hand-written sequences for priority, nesting, collisions and reset behaviour.
module tb_intc;

  typedef struct {
    logic        sel;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  irq;
    logic [31:0] expData;
    logic        expHw;
  } vec_t;

  localparam logic [1:0] A_PEND  = 2'd0;
  localparam logic [1:0] A_EN    = 2'd1;
  localparam logic [1:0] A_CLAIM = 2'd2;
  localparam logic [1:0] A_EOI   = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  intc_if busIf ();

  intc dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic s, input logic r, input logic w,
                                 input logic [1:0] a, input logic [31:0] d,
                                 input logic [7:0] i, input logic [31:0] ed,
                                 input logic eh);
    vec_t v;
    v.sel = s; v.rd = r; v.wr = w; v.addr = a; v.wdata = d;
    v.irq = i; v.expData = ed; v.expHw = eh;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one bus cycle starting just after a rising edge, samples mid-cycle,
  // then lets the following edge commit it.
  task automatic applyStimulus(input vec_t v, output logic [31:0] rdata, output logic hw);
    busIf.sel     = v.sel;
    busIf.rd      = v.rd;
    busIf.wr      = v.wr;
    busIf.addr    = v.addr;
    busIf.data_in = v.wdata;
    busIf.irq     = v.irq;
    #4;
    rdata = busIf.data_out;
    hw    = busIf.hwint;
    @(posedge clk);
    #1;
    busIf.sel = 1'b0;
    busIf.rd  = 1'b0;
    busIf.wr  = 1'b0;
  endtask

  task automatic op(input logic s, input logic r, input logic w, input logic [1:0] a,
                    input logic [31:0] d, input logic [7:0] i,
                    output logic [31:0] rdata, output logic hw);
    applyStimulus(mkVec(s, r, w, a, d, i, 32'd0, 1'b0), rdata, hw);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        table_q[$];
    logic [31:0] rdata;
    logic        hw;

    busIf.irq = 8'h00; busIf.sel = 1'b0; busIf.rd = 1'b0; busIf.wr = 1'b0;
    busIf.addr = 2'd0; busIf.data_in = 32'd0;

    @(posedge clk); #1;
    op(1, 1, 0, A_EN, 32'd0, 8'h00, rdata, hw);
    checkOutput("reset_enable_read", rdata, 32'd0);
    checkOutput("reset_hwint", {31'd0, hw}, 32'd0);
    rst = 1'b0;
    op(0, 0, 0, A_PEND, 32'd0, 8'h00, rdata, hw);
    op(1, 1, 0, A_PEND, 32'd0, 8'h00, rdata, hw);
    checkOutput("post_reset_pending", rdata, 32'd0);

    // Single-source flow, register access rules and disabled-source latching.
    table_q.push_back(mkVec(1, 0, 1, A_EN,    32'h04,        8'h00, 32'h0,        0));
    table_q.push_back(mkVec(0, 0, 0, A_PEND,  32'h0,         8'h04, 32'h0,        0));
    table_q.push_back(mkVec(1, 1, 0, A_PEND,  32'h0,         8'h00, 32'h04,       0));
    table_q.push_back(mkVec(0, 0, 0, A_PEND,  32'h0,         8'h00, 32'h0,        1));
    table_q.push_back(mkVec(1, 1, 0, A_CLAIM, 32'h0,         8'h00, 32'h80000002, 1));
    table_q.push_back(mkVec(1, 1, 0, A_PEND,  32'h0,         8'h00, 32'h0,        1));
    table_q.push_back(mkVec(1, 1, 0, A_EOI,   32'h0,         8'h00, 32'h04,       0));
    table_q.push_back(mkVec(1, 0, 1, A_EOI,   32'hFFFFFFFA,  8'h00, 32'h0,        0));
    table_q.push_back(mkVec(1, 1, 0, A_EOI,   32'h0,         8'h00, 32'h0,        0));
    table_q.push_back(mkVec(1, 1, 0, A_CLAIM, 32'h0,         8'h00, 32'h0,        0));
    table_q.push_back(mkVec(1, 1, 1, A_EN,    32'hFF,        8'h00, 32'h04,       0));
    table_q.push_back(mkVec(1, 1, 0, A_EN,    32'h0,         8'h00, 32'h04,       0));
    table_q.push_back(mkVec(0, 0, 1, A_EN,    32'hFF,        8'h00, 32'h0,        0));
    table_q.push_back(mkVec(1, 1, 0, A_EN,    32'h0,         8'h00, 32'h04,       0));
    table_q.push_back(mkVec(1, 0, 1, A_CLAIM, 32'hFFFFFFFF,  8'h00, 32'h0,        0));
    table_q.push_back(mkVec(1, 1, 0, A_EOI,   32'h0,         8'h00, 32'h0,        0));
    table_q.push_back(mkVec(1, 1, 0, A_PEND,  32'h0,         8'h00, 32'h0,        0));
    table_q.push_back(mkVec(0, 0, 0, A_PEND,  32'h0,         8'h10, 32'h0,        0));
    table_q.push_back(mkVec(1, 1, 0, A_PEND,  32'h0,         8'h00, 32'h10,       0));
    table_q.push_back(mkVec(0, 0, 0, A_PEND,  32'h0,         8'h00, 32'h0,        0));
    table_q.push_back(mkVec(1, 0, 1, A_PEND,  32'h10,        8'h00, 32'h0,        0));
    table_q.push_back(mkVec(1, 1, 0, A_PEND,  32'h0,         8'h00, 32'h0,        0));
    table_q.push_back(mkVec(0, 1, 0, A_EN,    32'h0,         8'h00, 32'h0,        0));
    table_q.push_back(mkVec(1, 0, 1, A_EOI,   32'h5,         8'h00, 32'h0,        0));
    table_q.push_back(mkVec(1, 1, 0, A_EOI,   32'h0,         8'h00, 32'h0,        0));

    foreach (table_q[k]) begin
      applyStimulus(table_q[k], rdata, hw);
      checkOutput($sformatf("vec%0d_data", k), rdata, table_q[k].expData);
      checkOutput($sformatf("vec%0d_hwint", k), {31'd0, hw}, {31'd0, table_q[k].expHw});
    end

    // Two sources rising together are claimed in priority order.
    op(1, 0, 1, A_EN, 32'hFF, 8'h00, rdata, hw);
    op(0, 0, 0, A_PEND, 32'h0, 8'h22, rdata, hw);
    op(0, 0, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    op(1, 1, 0, A_CLAIM, 32'h0, 8'h00, rdata, hw);
    checkOutput("prio_claim_first", rdata, 32'h80000001);
    op(1, 1, 0, A_CLAIM, 32'h0, 8'h00, rdata, hw);
    checkOutput("prio_claim_second", rdata, 32'h80000005);
    op(1, 1, 0, A_EOI, 32'h0, 8'h00, rdata, hw);
    checkOutput("prio_in_service", rdata, 32'h22);
    op(1, 0, 1, A_EOI, 32'h1, 8'h00, rdata, hw);
    op(1, 1, 0, A_EOI, 32'h0, 8'h00, rdata, hw);
    checkOutput("prio_after_eoi1", rdata, 32'h20);
    checkOutput("prio_hwint_idle", {31'd0, hw}, 32'd0);
    op(1, 0, 1, A_EOI, 32'h5, 8'h00, rdata, hw);

    // Nesting: only a higher-priority source than the one in service raises hwint.
    op(0, 0, 0, A_PEND, 32'h0, 8'h08, rdata, hw);
    op(0, 0, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    op(1, 1, 0, A_CLAIM, 32'h0, 8'h00, rdata, hw);
    checkOutput("nest_claim3", rdata, 32'h80000003);
    op(0, 0, 0, A_PEND, 32'h0, 8'h40, rdata, hw);
    op(0, 0, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    op(0, 0, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    checkOutput("nest_low_no_hwint", {31'd0, hw}, 32'd0);
    op(0, 0, 0, A_PEND, 32'h0, 8'h01, rdata, hw);
    op(0, 0, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    checkOutput("nest_latency_hwint", {31'd0, hw}, 32'd0);
    op(0, 0, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    checkOutput("nest_high_hwint", {31'd0, hw}, 32'd1);
    op(1, 1, 0, A_CLAIM, 32'h0, 8'h00, rdata, hw);
    checkOutput("nest_claim0", rdata, 32'h80000000);
    op(1, 0, 1, A_EOI, 32'h0, 8'h00, rdata, hw);
    op(0, 0, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    op(0, 0, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    checkOutput("nest_blocked_by3", {31'd0, hw}, 32'd0);
    op(1, 0, 1, A_EOI, 32'h3, 8'h00, rdata, hw);
    op(0, 0, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    op(0, 0, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    checkOutput("nest_eoi3_hwint", {31'd0, hw}, 32'd1);
    op(1, 1, 0, A_CLAIM, 32'h0, 8'h00, rdata, hw);
    checkOutput("nest_claim6", rdata, 32'h80000006);
    op(1, 0, 1, A_EOI, 32'h6, 8'h00, rdata, hw);

    // Set beats W1C and claim on the same pending bit; claim without eligibility is inert.
    op(0, 0, 0, A_PEND, 32'h0, 8'h10, rdata, hw);
    op(0, 0, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    op(1, 0, 1, A_PEND, 32'h10, 8'h10, rdata, hw);
    op(1, 1, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    checkOutput("w1c_collision", rdata, 32'h10);
    op(1, 0, 1, A_EN, 32'h0, 8'h00, rdata, hw);
    op(1, 1, 0, A_CLAIM, 32'h0, 8'h00, rdata, hw);
    checkOutput("claim_disabled", rdata, 32'h0);
    op(1, 1, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    checkOutput("claim_disabled_pend", rdata, 32'h10);
    op(1, 1, 0, A_EOI, 32'h0, 8'h00, rdata, hw);
    checkOutput("claim_disabled_eoi", rdata, 32'h0);
    op(1, 0, 1, A_EN, 32'h10, 8'h00, rdata, hw);
    op(1, 1, 0, A_CLAIM, 32'h0, 8'h10, rdata, hw);
    checkOutput("claim_collision_data", rdata, 32'h80000004);
    op(1, 1, 0, A_PEND, 32'h0, 8'h00, rdata, hw);
    checkOutput("claim_collision_pend", rdata, 32'h10);
    op(1, 1, 0, A_EOI, 32'h0, 8'h00, rdata, hw);
    checkOutput("claim_collision_eoi", rdata, 32'h10);

    // Sources held high across reset release must not latch.
    rst = 1'b1;
    op(1, 1, 0, A_EN, 32'h0, 8'hFF, rdata, hw);
    checkOutput("rst_enable_read", rdata, 32'h0);
    checkOutput("rst_hwint", {31'd0, hw}, 32'd0);
    op(0, 0, 0, A_PEND, 32'h0, 8'hFF, rdata, hw);
    rst = 1'b0;
    op(0, 0, 0, A_PEND, 32'h0, 8'hFF, rdata, hw);
    op(1, 1, 0, A_PEND, 32'h0, 8'hFF, rdata, hw);
    checkOutput("held_irq_pending", rdata, 32'h0);
    op(0, 0, 0, A_PEND, 32'h0, 8'h7F, rdata, hw);
    op(0, 0, 0, A_PEND, 32'h0, 8'hFF, rdata, hw);
    op(1, 1, 0, A_PEND, 32'h0, 8'hFF, rdata, hw);
    checkOutput("rerise_irq7", rdata, 32'h80);
    op(1, 0, 1, A_EN, 32'hFF, 8'hFF, rdata, hw);

    // Reset asserted during a claim read discards the claim.
    busIf.sel = 1'b1; busIf.rd = 1'b1; busIf.wr = 1'b0; busIf.addr = A_CLAIM;
    #1;
    checkOutput("claim_before_rst", busIf.data_out, 32'h80000007);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("claim_during_rst", busIf.data_out, 32'h0);
    @(posedge clk); #1;
    busIf.sel = 1'b0; busIf.rd = 1'b0;
    rst = 1'b0;
    op(1, 1, 0, A_PEND, 32'h0, 8'hFF, rdata, hw);
    checkOutput("rst_claim_pending", rdata, 32'h0);
    op(1, 1, 0, A_EN, 32'h0, 8'hFF, rdata, hw);
    checkOutput("rst_claim_enable", rdata, 32'h0);
    op(1, 1, 0, A_EOI, 32'h0, 8'hFF, rdata, hw);
    checkOutput("rst_claim_eoi", rdata, 32'h0);
    checkOutput("rst_claim_hwint", {31'd0, hw}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
